// File: rtl/doorlock_pkg.sv
// Shared encodings for the door lock: lock states, special key codes and keypad FSM states.
// Helper functions classify and encode the synchronized one-hot key vector.
package doorlock_pkg;

    localparam logic [1:0] STATE_IDLE  = 2'b00;
    localparam logic [1:0] STATE_START = 2'b01;
    localparam logic [1:0] STATE_END   = 2'b10;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    typedef enum logic [1:0] {
        K_IDLE  = 2'd0,
        K_PRESS = 2'd1,
        K_HELD  = 2'd2,
        K_REL   = 2'd3
    } kstate_t;

    function automatic logic key_onehot(input logic [11:0] v);
        return (v != 12'd0) && ((v & (v - 12'd1)) == 12'd0);
    endfunction

    function automatic logic [3:0] key_encode(input logic [11:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (v[i]) c = 4'(i);
        end
        return c;
    endfunction

    // The unused 2'b11 encoding behaves as IDLE.
    function automatic logic lock_idle(input logic [1:0] s);
        return (s == STATE_IDLE) || (s == 2'b11);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes the raw keypad, rejects chords and emits one key event per debounced press.
// key_evt is a single-cycle strobe with key_code valid alongside it; there is no backpressure.
module key_debounce
    import doorlock_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] key_in,
    output logic        key_evt,
    output logic [3:0]  key_code,
    output kstate_t     state
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [11:0]   sync1;
    logic [11:0]   sync2;
    logic [CW-1:0] cnt;
    logic          valid;
    logic [3:0]    code_now;
    logic          same;

    assign valid    = key_onehot(sync2);
    assign code_now = key_encode(sync2);
    assign same     = valid && (code_now == key_code);

    // Decoded from registers so the top can register its pulses on the same edge as the FSM moves to K_HELD.
    assign key_evt = (state == K_PRESS) && same && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= '0;
            sync2    <= '0;
            state    <= K_IDLE;
            cnt      <= '0;
            key_code <= '0;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
            case (state)
                K_IDLE: begin
                    if (valid) begin
                        state    <= K_PRESS;
                        key_code <= code_now;
                        cnt      <= '0;
                    end
                end
                K_PRESS: begin
                    if (!same)                 state <= K_IDLE;
                    else if (cnt == CNT_LAST)  state <= K_HELD;
                    else                       cnt   <= cnt + 1'b1;
                end
                K_HELD: begin
                    if (sync2 == 12'd0) begin
                        state <= K_REL;
                        cnt   <= '0;
                    end
                end
                K_REL: begin
                    if (sync2 != 12'd0)        state <= K_HELD;
                    else if (cnt == CNT_LAST)  state <= K_IDLE;
                    else                       cnt   <= cnt + 1'b1;
                end
                default: state <= K_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/doorlock_keypad_ctrl.sv
// Keypad front end of the door lock: turns debounced key events into ps_start/ps_end requests
// and checks the collected digits against the stored code.
module doorlock_keypad_ctrl
    import doorlock_pkg::*;
#(
    parameter int          DEBOUNCE_CYC = 20,
    parameter int          PW_LEN       = 4,
    parameter logic [15:0] PASSWORD     = 16'h1234
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] key_in,
    input  logic [1:0]  state_in,
    output logic        ps_start,
    output logic        ps_end,
    output logic [2:0]  digit_cnt,
    output logic [15:0] entry,
    output logic        unlock,
    output logic        err,
    output kstate_t     kb_state
);

    localparam logic [2:0] PW_MAX = 3'(PW_LEN);

    logic       key_evt;
    logic [3:0] key_code;
    logic       match;
    logic       overflow;
    logic [1:0] state_q;
    logic       entering_idle;
    logic       code_ok;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .key_evt  (key_evt),
        .key_code (key_code),
        .state    (kb_state)
    );

    assign entering_idle = lock_idle(state_in) && !lock_idle(state_q);
    assign code_ok       = (digit_cnt == PW_MAX) && !overflow && (entry == PASSWORD);
    assign unlock        = match && (state_in == STATE_END);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_start  <= 1'b0;
            ps_end    <= 1'b0;
            err       <= 1'b0;
            digit_cnt <= '0;
            entry     <= '0;
            match     <= 1'b0;
            overflow  <= 1'b0;
            state_q   <= STATE_IDLE;
        end else begin
            state_q  <= state_in;
            ps_start <= 1'b0;
            ps_end   <= 1'b0;
            err      <= 1'b0;
            if (entering_idle) begin
                entry     <= '0;
                digit_cnt <= '0;
                overflow  <= 1'b0;
                match     <= 1'b0;
            end
            // Event decoding uses the current lock state, so it overrides the idle clear above.
            if (key_evt) begin
                if (key_code == KEY_STAR && lock_idle(state_in)) begin
                    ps_start  <= 1'b1;
                    entry     <= '0;
                    digit_cnt <= '0;
                    overflow  <= 1'b0;
                    match     <= 1'b0;
                end else if (key_code <= 4'd9 && state_in == STATE_START) begin
                    if (digit_cnt < PW_MAX) begin
                        entry     <= {entry[11:0], key_code};
                        digit_cnt <= digit_cnt + 3'd1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end else if (key_code == KEY_HASH && state_in == STATE_START) begin
                    ps_end <= 1'b1;
                    match  <= code_ok;
                    err    <= !code_ok;
                end
            end
        end
    end

endmodule

// File: tb/tb_doorlock_keypad_ctrl.sv
// Directed bench for the keypad front end, with a small model of the lock state machine.
module tb_doorlock_keypad_ctrl;
    import doorlock_pkg::*;

    localparam int DEB     = 20;
    localparam int HOLD    = 30;
    localparam int GAP     = DEB + 10;
    localparam int END_TMO = 80;

    logic        clk;
    logic        rst;
    logic [11:0] key_in;
    logic [1:0]  state_in;
    logic        ps_start;
    logic        ps_end;
    logic [2:0]  digit_cnt;
    logic [15:0] entry;
    logic        unlock;
    logic        err;
    kstate_t     kb_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int key_cyc = 0;
    int start_cyc = 0;
    int n_start = 0;
    int n_end = 0;
    int n_err = 0;
    int n_overlap = 0;
    int tmo = 0;
    logic prev_pulse = 1'b0;

    doorlock_keypad_ctrl #(
        .DEBOUNCE_CYC (DEB),
        .PW_LEN       (4),
        .PASSWORD     (16'h1234)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .state_in  (state_in),
        .ps_start  (ps_start),
        .ps_end    (ps_end),
        .digit_cnt (digit_cnt),
        .entry     (entry),
        .unlock    (unlock),
        .err       (err),
        .kb_state  (kb_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // lock state machine model
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_in <= STATE_IDLE;
            tmo      <= 0;
        end else begin
            case (state_in)
                STATE_IDLE:  if (ps_start) state_in <= STATE_START;
                STATE_START: if (ps_end) begin state_in <= STATE_END; tmo <= 0; end
                STATE_END: begin
                    if (tmo == END_TMO - 1) state_in <= STATE_IDLE;
                    else tmo <= tmo + 1;
                end
                default: state_in <= STATE_IDLE;
            endcase
        end
    end

    // pulse monitor
    always @(negedge clk) begin
        if (ps_start) begin n_start <= n_start + 1; start_cyc <= cyc; end
        if (ps_end) n_end <= n_end + 1;
        if (err) n_err <= n_err + 1;
        if ((ps_start && ps_end) || (prev_pulse && (ps_start || ps_end))) n_overlap <= n_overlap + 1;
        prev_pulse <= ps_start || ps_end;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic press(input int k);
        @(negedge clk);
        key_in = '0;
        key_in[k] = 1'b1;
        key_cyc = cyc;
        repeat (HOLD) @(negedge clk);
        key_in = '0;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (state_in != STATE_IDLE && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", 32'(state_in), 32'(STATE_IDLE));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int s0, e0, r0;
        rst = 1'b0;
        key_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // reset state
        check("rst_ps_start", 32'(ps_start), 0);
        check("rst_ps_end", 32'(ps_end), 0);
        check("rst_digit_cnt", 32'(digit_cnt), 0);
        check("rst_entry", 32'(entry), 0);
        check("rst_unlock", 32'(unlock), 0);
        check("rst_err", 32'(err), 0);
        check("rst_kb_state", 32'(kb_state), 32'(K_IDLE));

        // 1: '*' in IDLE, single pulse with fixed latency
        press(10);
        check("t1_start_cnt", 32'(n_start), 1);
        check("t1_latency", 32'(start_cyc - key_cyc - 1), 32'(2 + DEB));
        check("t1_state", 32'(state_in), 32'(STATE_START));
        check("t1_kb_idle", 32'(kb_state), 32'(K_IDLE));

        // 6a: '*' in START does nothing; '#' with no digits errors
        press(10);
        check("t6_star_in_start", 32'(n_start), 1);
        press(11);
        check("t6_hash_end", 32'(n_end), 1);
        check("t6_hash_err", 32'(n_err), 1);
        wait_idle();

        // 2: correct code
        press(10); press(1); press(2); press(3); press(4);
        check("t2_entry", 32'(entry), 32'h1234);
        check("t2_cnt", 32'(digit_cnt), 4);
        check("t2_unlock_start", 32'(unlock), 0);
        press(11);
        check("t2_end_cnt", 32'(n_end), 2);
        check("t2_err_cnt", 32'(n_err), 1);
        check("t2_unlock", 32'(unlock), 1);
        wait_idle();
        check("t2_unlock_idle", 32'(unlock), 0);
        check("t2_entry_clr", 32'(entry), 0);
        check("t2_cnt_clr", 32'(digit_cnt), 0);

        // 3: short code
        press(10); press(1); press(2); press(3);
        check("t3_entry", 32'(entry), 32'h0123);
        check("t3_cnt", 32'(digit_cnt), 3);
        press(11);
        check("t3_end_cnt", 32'(n_end), 3);
        check("t3_err_cnt", 32'(n_err), 2);
        check("t3_unlock", 32'(unlock), 0);
        check("t3_entry_end", 32'(entry), 32'h0123);
        wait_idle();

        // 4: overflow digit
        press(10); press(1); press(2); press(3); press(4); press(5);
        check("t4_entry", 32'(entry), 32'h1234);
        check("t4_cnt", 32'(digit_cnt), 4);
        press(11);
        check("t4_err_cnt", 32'(n_err), 3);
        check("t4_unlock", 32'(unlock), 0);
        wait_idle();

        // 5: glitch and chord rejection
        press(10);
        @(negedge clk);
        key_in = 12'h002;
        repeat (10) @(negedge clk);
        key_in = '0;
        repeat (GAP) @(negedge clk);
        check("t5_glitch_cnt", 32'(digit_cnt), 0);
        key_in = 12'h006;
        repeat (50) @(negedge clk);
        key_in = '0;
        repeat (GAP) @(negedge clk);
        check("t5_chord_cnt", 32'(digit_cnt), 0);
        check("t5_chord_entry", 32'(entry), 0);
        press(7);
        check("t5_after_entry", 32'(entry), 32'h0007);
        press(11);
        wait_idle();

        // 6b: digit and '#' in IDLE are ignored
        s0 = n_start; e0 = n_end; r0 = n_err;
        press(5);
        press(11);
        check("t6_idle_cnt", 32'(digit_cnt), 0);
        check("t6_idle_start", 32'(n_start), 32'(s0));
        check("t6_idle_end", 32'(n_end), 32'(e0));
        check("t6_idle_err", 32'(n_err), 32'(r0));

        // 6c: asynchronous reset mid-entry, key still held afterwards
        press(10); press(9); press(8);
        check("t6_pre_rst_entry", 32'(entry), 32'h0098);
        @(negedge clk);
        key_in = '0;
        key_in[7] = 1'b1;
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_entry", 32'(entry), 0);
        check("t6_rst_cnt", 32'(digit_cnt), 0);
        check("t6_rst_pulses", {29'd0, ps_start, ps_end, err}, 0);
        check("t6_rst_unlock", 32'(unlock), 0);
        check("t6_rst_kb", 32'(kb_state), 32'(K_IDLE));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (HOLD) @(negedge clk);
        check("t6_held_after_rst", 32'(kb_state), 32'(K_HELD));
        check("t6_held_cnt", 32'(digit_cnt), 0);
        key_in = '0;
        repeat (GAP) @(negedge clk);
        check("t6_released", 32'(kb_state), 32'(K_IDLE));

        check("no_overlap_pulses", 32'(n_overlap), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
